snax_alu_csr_mc: RTL and testbench

Multi-channel CSR and job-control block for the SNAX ALU accelerator. It sits between the CSR manager and an array of `NumChannels` ALU processing elements. It supplies a per-channel operation code and tracks job length across all channels' output handshakes. A one-deep pending-job slot lets software stage the next job while the current one runs, giving back-to-back jobs with no idle cycle. It exposes busy, pending, error, performance and job-count status as read-only registers.

---
 rtl/snax_alu_csr_mc_if.sv | 28 ++
 rtl/snax_alu_csr_mc.sv | 169 ++++++++++++++++
 tb/tb_snax_alu_csr_mc.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/snax_alu_csr_mc_if.sv
// CSR write/read bus between the CSR manager and snax_alu_csr_mc.
//   csr_reg_set_i        : RW word set (0 opcodes, 1 job length, 2 control)
//   csr_reg_set_valid_i  : write request
//   csr_reg_set_ready_o  : write accept
//   csr_reg_ro_set_o     : RO word set (0 status, 1 perf, 2 job count)
// The _i/_o suffixes are named from the block's point of view.
interface snax_alu_csr_mc_if #(
  parameter int RegDataWidth = 32
);
  logic [2:0][RegDataWidth-1:0] csr_reg_set_i;
  logic                         csr_reg_set_valid_i;
  logic                         csr_reg_set_ready_o;
  logic [2:0][RegDataWidth-1:0] csr_reg_ro_set_o;

  modport master (
    output csr_reg_set_i,
    output csr_reg_set_valid_i,
    input  csr_reg_set_ready_o,
    input  csr_reg_ro_set_o
  );

  modport slave (
    input  csr_reg_set_i,
    input  csr_reg_set_valid_i,
    output csr_reg_set_ready_o,
    output csr_reg_ro_set_o
  );
endinterface

// File: rtl/snax_alu_csr_mc.sv
// CSR and job-control block for the SNAX ALU accelerator.
// Latches per-channel opcodes and a job length at launch, counts output
// strobes from all channels until the length is reached, and offers a
// one-deep pending slot so the next job starts with no idle cycle.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   csr                   : CSR bus (slave side)
//   acc_output_success_i  : per-channel output-written strobe
//   csr_alu_config_o      : active opcode per channel
//   acc_busy_o            : job active
//   acc_done_o            : one-cycle job-complete pulse
//
// state   | meaning
// ST_IDLE | no job running, strobes ignored
// ST_BUSY | job running, counting strobes against len_active
module snax_alu_csr_mc #(
  parameter int NumChannels  = 4,
  parameter int OpWidth      = 2,
  parameter int RegDataWidth = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  snax_alu_csr_mc_if.slave                      csr,
  input  logic [NumChannels-1:0]                acc_output_success_i,
  output logic [NumChannels-1:0][OpWidth-1:0]   csr_alu_config_o,
  output logic                                  acc_busy_o,
  output logic                                  acc_done_o
);

  localparam int CfgW = NumChannels * OpWidth;
  localparam int IncW = $clog2(NumChannels + 1);
  localparam int SumW = RegDataWidth + 1;

  if (CfgW > RegDataWidth) begin : g_cfg_check
    $error("NumChannels*OpWidth must not exceed RegDataWidth");
  end

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t                  state;
  logic [CfgW-1:0]         cfg_active;
  logic [RegDataWidth-1:0] len_active;
  logic [RegDataWidth-1:0] count;
  logic [RegDataWidth-1:0] perf;
  logic [RegDataWidth-1:0] jobs;
  logic                    pend_valid;
  logic [CfgW-1:0]         pend_cfg;
  logic [RegDataWidth-1:0] pend_len;
  logic                    error;
  logic                    done;

  logic                    ready;
  logic                    acc;
  logic [CfgW-1:0]         ops_w;
  logic [RegDataWidth-1:0] len_w;
  logic                    start_w;
  logic                    clr_w;
  logic                    len_zero;
  logic                    launch_req;
  logic [IncW-1:0]         inc;
  logic [SumW-1:0]         sum;
  logic                    finish;

  assign ops_w      = csr.csr_reg_set_i[0][CfgW-1:0];
  assign len_w      = csr.csr_reg_set_i[1];
  assign start_w    = csr.csr_reg_set_i[2][0];
  assign clr_w      = csr.csr_reg_set_i[2][1];
  assign len_zero   = (len_w == '0);

  assign ready      = !((state == ST_BUSY) && pend_valid);
  assign acc        = csr.csr_reg_set_valid_i && ready;
  assign launch_req = acc && start_w && !len_zero;

  always_comb begin
    inc = '0;
    for (int c = 0; c < NumChannels; c++) begin
      inc = inc + IncW'(acc_output_success_i[c]);
    end
  end

  // One extra bit so count + inc can never wrap past len_active.
  assign sum    = {1'b0, count} + SumW'(inc);
  assign finish = (state == ST_BUSY) && (sum >= {1'b0, len_active});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      cfg_active <= '0;
      len_active <= '0;
      count      <= '0;
      perf       <= '0;
      jobs       <= '0;
      pend_valid <= 1'b0;
      pend_cfg   <= '0;
      pend_len   <= '0;
      error      <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;

      if (acc && start_w && len_zero) begin
        error <= 1'b1;
      end else if (acc && clr_w) begin
        error <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (launch_req) begin
            state      <= ST_BUSY;
            cfg_active <= ops_w;
            len_active <= len_w;
            count      <= '0;
            perf       <= '0;
          end
        end
        ST_BUSY: begin
          perf <= perf + 1'b1;
          if (finish) begin
            done <= 1'b1;
            jobs <= jobs + 1'b1;
            // Strobes beyond the length are dropped: count restarts at 0.
            if (pend_valid) begin
              cfg_active <= pend_cfg;
              len_active <= pend_len;
              count      <= '0;
              perf       <= '0;
              pend_valid <= 1'b0;
            end else if (launch_req) begin
              cfg_active <= ops_w;
              len_active <= len_w;
              count      <= '0;
              perf       <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            count <= sum[RegDataWidth-1:0];
            // ready guarantees the slot is empty whenever acc is high here.
            if (launch_req) begin
              pend_valid <= 1'b1;
              pend_cfg   <= ops_w;
              pend_len   <= len_w;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign csr.csr_reg_set_ready_o = ready;
  assign csr.csr_reg_ro_set_o[0] = {{(RegDataWidth-3){1'b0}}, error, pend_valid,
                                    (state == ST_BUSY)};
  assign csr.csr_reg_ro_set_o[1] = perf;
  assign csr.csr_reg_ro_set_o[2] = jobs;

  assign csr_alu_config_o = cfg_active;
  assign acc_busy_o       = (state == ST_BUSY);
  assign acc_done_o       = done;

  logic unused_ctl_bits;
  if (CfgW < RegDataWidth) begin : g_unused_ops
    assign unused_ctl_bits = ^{csr.csr_reg_set_i[2][RegDataWidth-1:2],
                               csr.csr_reg_set_i[0][RegDataWidth-1:CfgW]};
  end else begin : g_unused_ctl
    assign unused_ctl_bits = ^csr.csr_reg_set_i[2][RegDataWidth-1:2];
  end

endmodule

// File: tb/tb_snax_alu_csr_mc.sv
// Directed testbench for snax_alu_csr_mc. Inputs change and outputs are
// sampled on the falling clock edge; expected values are hand-computed.
module tb_snax_alu_csr_mc;

  logic       clk;
  logic       rst;
  logic [3:0] strb;
  logic [3:0][1:0] cfg;
  logic       busy;
  logic       done;

  int n_vec  = 0;
  int n_miss = 0;
  int done_cnt = 0;
  int base;

  snax_alu_csr_mc_if #(.RegDataWidth(32)) csr_if ();

  snax_alu_csr_mc #(
    .NumChannels (4),
    .OpWidth     (2),
    .RegDataWidth(32)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .csr                 (csr_if.slave),
    .acc_output_success_i(strb),
    .csr_alu_config_o    (cfg),
    .acc_busy_o          (busy),
    .acc_done_o          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (done) done_cnt++;
  endtask

  task automatic wr(input logic [31:0] ops, input logic [31:0] len, input logic [31:0] ctl);
    csr_if.csr_reg_set_valid_i = 1'b1;
    csr_if.csr_reg_set_i[0]    = ops;
    csr_if.csr_reg_set_i[1]    = len;
    csr_if.csr_reg_set_i[2]    = ctl;
  endtask

  task automatic wr_end();
    csr_if.csr_reg_set_valid_i = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    strb = '0;
    csr_if.csr_reg_set_valid_i = 1'b0;
    csr_if.csr_reg_set_i       = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_ro0", csr_if.csr_reg_ro_set_o[0], 32'h0);
    chk("rst_ro1", csr_if.csr_reg_ro_set_o[1], 32'h0);
    chk("rst_ro2", csr_if.csr_reg_ro_set_o[2], 32'h0);
    chk("rst_ready", 32'(csr_if.csr_reg_set_ready_o), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_cfg", 32'(cfg), 32'h0);

    // single job: ops 0x1B, len 8, one strobe per cycle on ch0
    base = done_cnt;
    wr(32'h1B, 32'd8, 32'h1);
    tick();
    wr_end();
    chk("t1_cfg", 32'(cfg), 32'h1B);
    chk("t1_ch3", 32'(cfg[3]), 32'h0);
    chk("t1_ch0", 32'(cfg[0]), 32'h3);
    for (int i = 0; i < 8; i++) begin
      chk("t1_busy", 32'(busy), 32'h1);
      chk("t1_nodone", 32'(done), 32'h0);
      strb = 4'h1;
      tick();
    end
    strb = '0;
    chk("t1_idle", 32'(busy), 32'h0);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_perf", csr_if.csr_reg_ro_set_o[1], 32'd8);
    chk("t1_jobs", csr_if.csr_reg_ro_set_o[2], 32'd1);
    tick();
    chk("t1_done_low", 32'(done), 32'h0);
    chk("t1_pulses", 32'(done_cnt - base), 32'd1);
    // strobes while idle are ignored
    strb = 4'hF;
    tick(); tick();
    strb = '0;
    chk("t1_idle_perf", csr_if.csr_reg_ro_set_o[1], 32'd8);
    chk("t1_idle_jobs", csr_if.csr_reg_ro_set_o[2], 32'd1);
    chk("t1_idle_busy", 32'(busy), 32'h0);

    // multi-channel with overshoot: len 6, strobes 0xF twice
    base = done_cnt;
    wr(32'hE4, 32'd6, 32'h1);
    tick();
    wr_end();
    chk("t2_cfg", 32'(cfg), 32'hE4);
    strb = 4'hF;
    tick();
    chk("t2_busy", 32'(busy), 32'h1);
    chk("t2_nodone", 32'(done), 32'h0);
    tick();
    strb = '0;
    chk("t2_idle", 32'(busy), 32'h0);
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_jobs", csr_if.csr_reg_ro_set_o[2], 32'd2);
    chk("t2_perf", csr_if.csr_reg_ro_set_o[1], 32'd2);
    tick();
    chk("t2_pulses", 32'(done_cnt - base), 32'd1);

    // back-to-back: A len 4, B len 2 staged during A
    base = done_cnt;
    wr(32'h55, 32'd4, 32'h1);
    tick();
    wr(32'hAA, 32'd2, 32'h1);
    strb = 4'h1;
    tick();
    wr_end();
    for (int i = 0; i < 3; i++) begin
      chk("t3_pend_ro0", csr_if.csr_reg_ro_set_o[0], 32'h3);
      chk("t3_ready_low", 32'(csr_if.csr_reg_set_ready_o), 32'h0);
      chk("t3_cfg_a", 32'(cfg), 32'h55);
      tick();
    end
    chk("t3_busy_b", 32'(busy), 32'h1);
    chk("t3_cfg_b", 32'(cfg), 32'hAA);
    chk("t3_done_a", 32'(done), 32'h1);
    chk("t3_ro0_b", csr_if.csr_reg_ro_set_o[0], 32'h1);
    chk("t3_ready_b", 32'(csr_if.csr_reg_set_ready_o), 32'h1);
    chk("t3_jobs_a", csr_if.csr_reg_ro_set_o[2], 32'd3);
    chk("t3_perf_b0", csr_if.csr_reg_ro_set_o[1], 32'd0);
    tick();
    chk("t3_busy_b1", 32'(busy), 32'h1);
    chk("t3_nodone_b1", 32'(done), 32'h0);
    tick();
    strb = '0;
    chk("t3_idle", 32'(busy), 32'h0);
    chk("t3_done_b", 32'(done), 32'h1);
    chk("t3_jobs_b", csr_if.csr_reg_ro_set_o[2], 32'd4);
    chk("t3_perf_b", csr_if.csr_reg_ro_set_o[1], 32'd2);
    tick();
    chk("t3_pulses", 32'(done_cnt - base), 32'd2);

    // zero length start, clear, and set-wins-over-clear
    wr(32'h0, 32'd0, 32'h1);
    tick();
    wr_end();
    chk("t4_err", csr_if.csr_reg_ro_set_o[0], 32'h4);
    chk("t4_busy", 32'(busy), 32'h0);
    wr(32'h0, 32'd0, 32'h2);
    tick();
    wr_end();
    chk("t4_clr", csr_if.csr_reg_ro_set_o[0], 32'h0);
    wr(32'h0, 32'd0, 32'h3);
    tick();
    wr_end();
    chk("t4_set_wins", csr_if.csr_reg_ro_set_o[0], 32'h4);
    wr(32'h0, 32'd0, 32'h2);
    tick();
    wr_end();
    chk("t4_clr2", csr_if.csr_reg_ro_set_o[0], 32'h0);

    // mid-job write without start leaves the active config alone
    wr(32'h1B, 32'd3, 32'h1);
    tick();
    wr(32'hFF, 32'd3, 32'h0);
    strb = 4'h1;
    tick();
    wr_end();
    chk("t5_cfg_hold", 32'(cfg), 32'h1B);
    chk("t5_ro0", csr_if.csr_reg_ro_set_o[0], 32'h1);
    tick();
    chk("t5_cfg_hold2", 32'(cfg), 32'h1B);
    chk("t5_busy", 32'(busy), 32'h1);
    tick();
    strb = '0;
    chk("t5_idle", 32'(busy), 32'h0);
    chk("t5_cfg_after", 32'(cfg), 32'h1B);
    chk("t5_jobs", csr_if.csr_reg_ro_set_o[2], 32'd5);
    chk("t5_perf", csr_if.csr_reg_ro_set_o[1], 32'd3);
    wr(32'h27, 32'd1, 32'h1);
    tick();
    wr_end();
    chk("t5_cfg_new", 32'(cfg), 32'h27);
    strb = 4'h8;
    tick();
    strb = '0;
    chk("t5_idle2", 32'(busy), 32'h0);
    chk("t5_jobs2", csr_if.csr_reg_ro_set_o[2], 32'd6);

    // reset mid-job with a pending job staged
    wr(32'h33, 32'd5, 32'h1);
    tick();
    wr(32'hCC, 32'd2, 32'h1);
    tick();
    wr_end();
    chk("t6_pend", csr_if.csr_reg_ro_set_o[0], 32'h3);
    base = done_cnt;
    rst  = 1'b1;
    strb = 4'hF;
    tick();
    rst  = 1'b0;
    strb = '0;
    chk("t6_ro0", csr_if.csr_reg_ro_set_o[0], 32'h0);
    chk("t6_ro1", csr_if.csr_reg_ro_set_o[1], 32'h0);
    chk("t6_ro2", csr_if.csr_reg_ro_set_o[2], 32'h0);
    chk("t6_ready", 32'(csr_if.csr_reg_set_ready_o), 32'h1);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_cfg", 32'(cfg), 32'h0);
    chk("t6_done", 32'(done), 32'h0);
    strb = 4'hF;
    tick();
    strb = '0;
    chk("t6_busy2", 32'(busy), 32'h0);
    chk("t6_perf2", csr_if.csr_reg_ro_set_o[1], 32'h0);
    tick();
    chk("t6_pulses", 32'(done_cnt - base), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
